ram_loader: RTL and testbench

- Writer-side counterpart to the 16x8 program memory: receives a program image as a byte stream and writes it into RAM through a write port.
- After writing, reads every word back through the memory's combinational read path and checks it against a trailing checksum byte.
- Asserts cpu_hold from load start until verification passes, keeping the controller and MAR idle while RAM is being rewritten.

---
 rtl/ram_loader_pkg.sv | 20 ++
 rtl/ram_loader_sum.sv | 25 ++
 rtl/ram_loader.sv | 145 ++++++++++++++
 tb/tb_ram_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and defaults for the program-memory loader.
// Holds the FSM encoding and the width/depth constants.
package ram_loader_pkg;

  localparam int ADDR_W_D = 4;
  localparam int DATA_W_D = 8;
  localparam int DEPTH_D  = 16;
  localparam int SUM_W    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    CHK     = 3'd2,
    VERIFY  = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

endpackage

// File: rtl/ram_loader_sum.sv
// Modulo 2**W accumulator with synchronous clear and add enable.
// Used for both the stream checksum and the readback checksum.
module ram_loader_sum
  import ram_loader_pkg::*;
#(
  parameter int W = SUM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  output logic [W-1:0] val
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      val <= '0;
    else if (clr)
      val <= '0;
    else if (add)
      val <= val + din;
  end

endmodule

// File: rtl/ram_loader.sv
// Streams a program image into RAM, reads it back and checks it
// against a trailing checksum, holding the CPU while it works.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH  = DEPTH_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t state, state_n;

  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] chk;
  logic [DATA_W-1:0] rx_sum;
  logic [DATA_W-1:0] rd_sum;
  logic              clr;
  logic              rx_add;
  logic              rd_add;
  logic              hs;

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    hs       = 1'b0;
    clr      = 1'b0;
    rx_add   = 1'b0;
    rd_add   = 1'b0;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_n = RECV;
          clr     = 1'b1;
        end
      end
      RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        hs       = in_valid;
        rx_add   = in_valid;
        if (in_valid && wcnt == LAST)
          state_n = CHK;
      end
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid)
          state_n = VERIFY;
      end
      VERIFY: begin
        busy   = 1'b1;
        rd_add = 1'b1;
        if (raddr == LAST)
          state_n = COMPARE;
      end
      COMPARE: begin
        busy = 1'b1;
        if (rd_sum == rx_sum && rx_sum == chk)
          state_n = DONE;
        else
          state_n = ERROR;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // The checksum byte only lands in chk; it never reaches the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= '0;
      raddr     <= '0;
      chk       <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (clr) begin
        wcnt  <= '0;
        raddr <= '0;
      end
      if (hs) begin
        mem_we    <= 1'b1;
        mem_waddr <= wcnt;
        mem_wdata <= in_data;
        wcnt      <= wcnt + 1'b1;
      end
      if (state == CHK && in_valid)
        chk <= in_data;
      if (rd_add)
        raddr <= raddr + 1'b1;
    end
  end

  ram_loader_sum #(.W(DATA_W)) u_rx_sum (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .add (rx_add),
    .din (in_data),
    .val (rx_sum)
  );

  ram_loader_sum #(.W(DATA_W)) u_rd_sum (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .add (rd_add),
    .din (mem_rdata),
    .val (rd_sum)
  );

  assign mem_raddr = raddr;
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign cpu_hold  = busy | error;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader with a 16x8 RAM model.
// Writes are checked by a monitor; status by directed checks.
module tb_ram_loader;

  typedef logic [7:0] img_t [16];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;

  logic [7:0]  ram [16];
  logic        fault = 1'b0;
  logic [11:0] q [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mem_we) ram[mem_waddr] <= mem_wdata;

  assign mem_rdata = (fault && mem_raddr == 4'd5) ? 8'hFF : ram[mem_raddr];

  ram_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every write pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL write: unexpected addr %0h data %0h",
                 mem_waddr, mem_wdata);
      end else begin
        logic [11:0] e;
        e = q.pop_front();
        if ({mem_waddr, mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write: got %0h:%0h expected %0h:%0h",
                   mem_waddr, mem_wdata, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic load(input img_t img, input logic [7:0] ck,
                      input bit stall, input int stop_after,
                      output int t0);
    bit acc;
    logic [7:0] b;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 17; i++) begin
      if (i == stop_after) return;
      b = (i < 16) ? img[i] : ck;
      if (stall && i == 4) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      if (stall) repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      if (i < 16) q.push_back({4'(i), b});
      acc = 1'b0;
      for (int k = 0; k < 100 && !acc; k++) begin
        acc = in_ready;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) check("handshake timeout", 0, 1);
    end
  endtask

  task automatic wait_end(output int t1);
    for (int k = 0; k < 200 && !(done || error); k++) begin
      @(posedge clk); #1;
    end
    t1 = cyc;
    check("end reached", 32'(done | error), 1);
    check("write queue drained", q.size(), 0);
  endtask

  img_t seq, ones, a5;
  int t0, t1;

  initial begin
    for (int i = 0; i < 16; i++) begin
      seq[i]  = 8'(i);
      ones[i] = 8'h11;
      a5[i]   = 8'hA5;
    end

    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst cpu_hold", cpu_hold, 0);
    check("rst in_ready", in_ready, 0);
    check("rst mem_we", mem_we, 0);
    check("rst waddr/wdata/raddr", {mem_waddr, mem_wdata, mem_raddr}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic load, in_valid held high
    load(seq, 8'h78, 0, -1, t0);
    wait_end(t1);
    check("basic latency", t1 - t0, 34);
    check("basic done", done, 1);
    check("basic cpu_hold", cpu_hold, 0);
    check("basic busy", busy, 0);
    for (int i = 0; i < 16; i++)
      check("basic ram", ram[i], 8'(i));

    // Bad checksum
    load(seq, 8'h77, 0, -1, t0);
    wait_end(t1);
    check("badck error", error, 1);
    check("badck done", done, 0);
    check("badck cpu_hold", cpu_hold, 1);
    repeat (3) @(posedge clk);
    #1 check("badck hold stays", cpu_hold, 1);
    check("badck ram5", ram[5], 8'h05);
    check("badck ram15", ram[15], 8'h0F);

    // Readback fault at address 5
    fault = 1'b1;
    load(ones, 8'h10, 0, -1, t0);
    wait_end(t1);
    check("rdfault error", error, 1);
    check("rdfault done", done, 0);
    fault = 1'b0;

    // Reload from ERROR with stalls and a stray start during RECV
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("error clears", error, 0);
    check("hold after start", cpu_hold, 1);
    for (int i = 0; i < 17; i++) begin
      if (i == 4) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = (i < 16) ? 8'(15 - i) : 8'h78;
      if (i < 16) q.push_back({4'(i), 8'(15 - i)});
      t1 = 0;
      for (int k = 0; k < 100 && t1 == 0; k++) begin
        t1 = in_ready ? 1 : 0;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (t1 == 0) check("stall handshake timeout", 0, 1);
    end
    in_data = 8'hEE;
    in_valid = 1'b1;
    repeat (3) begin
      check("verify in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_end(t1);
    check("stall done", done, 1);
    check("stall ram0", ram[0], 8'h0F);
    check("stall ram15", ram[15], 8'h00);

    // Reset mid-load after 7 bytes
    load(a5, 8'h50, 0, 7, t0);
    rst = 1'b1;
    #1;
    check("midrst mem_we", mem_we, 0);
    check("midrst busy", busy, 0);
    check("midrst cpu_hold", cpu_hold, 0);
    check("midrst in_ready", in_ready, 0);
    check("midrst done/error", {done, error}, 0);
    check("midrst addrs", {mem_waddr, mem_wdata, mem_raddr}, 0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    load(a5, 8'h50, 0, -1, t0);
    wait_end(t1);
    check("reload done", done, 1);
    check("reload error", error, 0);
    check("reload ram9", ram[9], 8'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
